// File: rtl/vector_unit_pkg.sv
// Shared types and helpers for the vector multiplication path.
package vector_unit_pkg;

  localparam int XLEN       = 32;
  localparam int PROD_WIDTH = 64;

  typedef logic [XLEN-1:0] vector_t;

  typedef enum logic [1:0] {
    VLEN_8    = 2'b00,
    VLEN_16   = 2'b01,
    VLEN_32   = 2'b10,
    VLEN_RSVD = 2'b11
  } vec_len_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } vmul_seq_state_t;

  // Number of lanes packed in one 32-bit operand; the reserved code has none.
  function automatic logic [2:0] lane_count(input vec_len_t vlen);
    logic [2:0] n;
    case (vlen)
      VLEN_8:  n = 3'd4;
      VLEN_16: n = 3'd2;
      VLEN_32: n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vector_lane_extractor.sv
// Selects one lane of a packed operand and sign/zero-extends it to 32 bits.
module vector_lane_extractor
  import vector_unit_pkg::*;
(
  input  vector_t     vec_i,
  input  vec_len_t    vlen_i,
  input  logic [1:0]  idx_i,
  input  logic        sign_i,
  output logic [31:0] lane_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    case (idx_i)
      2'd0:    byte_s = vec_i[7:0];
      2'd1:    byte_s = vec_i[15:8];
      2'd2:    byte_s = vec_i[23:16];
      2'd3:    byte_s = vec_i[31:24];
      default: byte_s = 8'd0;
    endcase
    if (idx_i[0]) begin
      half_s = vec_i[31:16];
    end else begin
      half_s = vec_i[15:0];
    end
    case (vlen_i)
      VLEN_8:  lane_o = {{24{sign_i & byte_s[7]}}, byte_s};
      VLEN_16: lane_o = {{16{sign_i & half_s[15]}}, half_s};
      VLEN_32: lane_o = vec_i;
      default: lane_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/vector_mul_lane_sequencer.sv
// Serialises SIMD lanes over one shared 32x32 multiplier port and packs the
// double-width lane products into a 64-bit result.
module vector_mul_lane_sequencer #(
  parameter int XLEN       = 32,
  parameter int PROD_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic [XLEN-1:0]       vmultiplicand_i,
  input  logic [XLEN-1:0]       vmultiplier_i,
  input  logic [1:0]            vlen_i,
  input  logic [1:0]            signed_i,
  input  logic                  data_valid_i,
  output logic                  ready_o,
  output logic [31:0]           imul_operand_a_o,
  output logic [31:0]           imul_operand_b_o,
  output logic [1:0]            imul_signed_o,
  output logic                  imul_valid_o,
  input  logic                  imul_ready_i,
  input  logic [PROD_WIDTH-1:0] imul_result_i,
  input  logic                  imul_valid_i,
  output logic [PROD_WIDTH-1:0] vproduct_o,
  output logic                  vproduct_valid_o
);
  import vector_unit_pkg::*;

  vmul_seq_state_t       state_q, state_d;
  vector_t               a_q, a_d, b_q, b_d;
  vec_len_t              vlen_q, vlen_d;
  logic [1:0]            sgn_q, sgn_d;
  logic [1:0]            idx_q, idx_d;
  logic [PROD_WIDTH-1:0] prod_q, prod_d;
  logic [2:0]            n_lanes_s;
  logic                  last_lane_s;
  logic [3:0]            slot_we_s;
  logic [63:0]           slot_data_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (data_valid_i) begin
          state_d = (vec_len_t'(vlen_i) == VLEN_RSVD) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (imul_ready_i) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (imul_valid_i) begin
          state_d = last_lane_s ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o          = 1'b0;
    imul_valid_o     = 1'b0;
    vproduct_valid_o = 1'b0;
    case (state_q)
      ST_IDLE:  ready_o          = 1'b1;
      ST_ISSUE: imul_valid_o     = 1'b1;
      ST_DONE:  vproduct_valid_o = 1'b1;
      default:  ready_o          = 1'b0;
    endcase
  end

  assign imul_signed_o = sgn_q;
  assign vproduct_o    = prod_q;

  always_comb begin
    n_lanes_s   = lane_count(vlen_q);
    last_lane_s = ({1'b0, idx_q} == (n_lanes_s - 3'd1));
  end

  // Map the returned product onto 16-bit slots: a lane of width W owns 2W/16 slots.
  always_comb begin
    case (vlen_q)
      VLEN_8: begin
        slot_we_s   = 4'b0001 << idx_q;
        slot_data_s = {4{imul_result_i[15:0]}};
      end
      VLEN_16: begin
        slot_we_s   = idx_q[0] ? 4'b1100 : 4'b0011;
        slot_data_s = {2{imul_result_i[31:0]}};
      end
      VLEN_32: begin
        slot_we_s   = 4'b1111;
        slot_data_s = imul_result_i;
      end
      default: begin
        slot_we_s   = 4'b0000;
        slot_data_s = 64'd0;
      end
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    vlen_d = vlen_q;
    sgn_d  = sgn_q;
    idx_d  = idx_q;
    prod_d = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (data_valid_i) begin
          a_d    = vmultiplicand_i;
          b_d    = vmultiplier_i;
          vlen_d = vec_len_t'(vlen_i);
          sgn_d  = signed_i;
          idx_d  = 2'd0;
          prod_d = {PROD_WIDTH{1'b0}};
        end else begin
          idx_d = idx_q;
        end
      end
      ST_WAIT: begin
        if (imul_valid_i) begin
          for (int i = 0; i < 4; i++) begin
            if (slot_we_s[i]) begin
              prod_d[i*16 +: 16] = slot_data_s[i*16 +: 16];
            end else begin
              prod_d[i*16 +: 16] = prod_q[i*16 +: 16];
            end
          end
          idx_d = last_lane_s ? idx_q : (idx_q + 2'd1);
        end else begin
          idx_d = idx_q;
        end
      end
      default: idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      vlen_q <= VLEN_8;
      sgn_q  <= 2'd0;
      idx_q  <= 2'd0;
      prod_q <= {PROD_WIDTH{1'b0}};
    end else if (clk_en_i) begin
      a_q    <= a_d;
      b_q    <= b_d;
      vlen_q <= vlen_d;
      sgn_q  <= sgn_d;
      idx_q  <= idx_d;
      prod_q <= prod_d;
    end
  end

  vector_lane_extractor u_ext_a (
    .vec_i  (a_q),
    .vlen_i (vlen_q),
    .idx_i  (idx_q),
    .sign_i (sgn_q[1]),
    .lane_o (imul_operand_a_o)
  );

  vector_lane_extractor u_ext_b (
    .vec_i  (b_q),
    .vlen_i (vlen_q),
    .idx_i  (idx_q),
    .sign_i (sgn_q[0]),
    .lane_o (imul_operand_b_o)
  );

endmodule

// File: tb/tb_vector_mul_lane_sequencer.sv
// Randomised bench for vector_mul_lane_sequencer with a latency-varying multiplier model
// and a lane-arithmetic reference model.
module tb_vector_mul_lane_sequencer;

  logic        clk = 1'b0;
  logic        rst, clk_en, dv, ready_o;
  logic [31:0] a, b, op_a, op_b;
  logic [1:0]  vlen, sgn, imul_sgn;
  logic        imul_valid_o, imul_ready, imul_valid_in, vp_valid;
  logic [63:0] imul_result, vproduct;

  int n_cmp = 0;
  int n_bad = 0;
  int req_count = 0;
  int hold_low = 0;
  int lat_force = -1;
  bit fast = 1'b0;

  logic [63:0] exp_prod_q[$];
  logic [65:0] exp_lane_q[$];

  initial forever #5 clk = ~clk;

  vector_mul_lane_sequencer dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
    .vmultiplicand_i(a), .vmultiplier_i(b), .vlen_i(vlen), .signed_i(sgn),
    .data_valid_i(dv), .ready_o(ready_o),
    .imul_operand_a_o(op_a), .imul_operand_b_o(op_b), .imul_signed_o(imul_sgn),
    .imul_valid_o(imul_valid_o), .imul_ready_i(imul_ready),
    .imul_result_i(imul_result), .imul_valid_i(imul_valid_in),
    .vproduct_o(vproduct), .vproduct_valid_o(vp_valid)
  );

  function automatic void check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Extended lane i of width w taken from v, per the lane/sign rules.
  function automatic logic [31:0] lane_of(input logic [31:0] v, input int w, input int i, input bit s);
    logic [31:0] m, mask;
    if (w == 32) return v;
    mask = (32'd1 << w) - 32'd1;
    m = (v >> (i * w)) & mask;
    if (s && m[w-1]) m = m | ~mask;
    return m;
  endfunction

  function automatic logic [63:0] ext64(input logic [31:0] v, input bit s);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  function automatic void push_op(input logic [31:0] ta, input logic [31:0] tb2,
                                  input logic [1:0] tv, input logic [1:0] ts);
    int w, n;
    logic [63:0] res, p, mask;
    logic [31:0] la, lb;
    w = (tv == 2'd0) ? 8 : (tv == 2'd1) ? 16 : 32;
    n = (tv == 2'd0) ? 4 : (tv == 2'd1) ? 2 : (tv == 2'd2) ? 1 : 0;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    res = 64'd0;
    for (int i = 0; i < n; i++) begin
      la = lane_of(ta, w, i, ts[1]);
      lb = lane_of(tb2, w, i, ts[0]);
      p = ext64(la, ts[1]) * ext64(lb, ts[0]);
      res = res | ((p & mask) << (i * 2 * w));
      exp_lane_q.push_back({ts, la, lb});
    end
    exp_prod_q.push_back(res);
  endfunction

  // Reference model capture: every accepted operation.
  initial forever begin
    @(posedge clk);
    if (!rst && clk_en && dv && ready_o) push_op(a, b, vlen, sgn);
  end

  // Multiplier model: random ready, 0-5 cycle latency, product held until consumed.
  initial begin
    bit fire, consumed, pend;
    int cnt;
    logic [63:0] res;
    imul_ready = 1'b0;
    imul_valid_in = 1'b0;
    imul_result = 64'd0;
    pend = 1'b0;
    cnt = 0;
    res = 64'd0;
    forever begin
      @(posedge clk);
      fire = imul_valid_o && imul_ready && clk_en && !rst;
      consumed = imul_valid_in && clk_en;
      if (fire) res = ext64(op_a, imul_sgn[1]) * ext64(op_b, imul_sgn[0]);
      #1;
      if (consumed) imul_valid_in = 1'b0;
      if (fire) begin
        pend = 1'b1;
        req_count++;
        cnt = fast ? 0 : (lat_force >= 0) ? lat_force : int'($urandom_range(0, 5));
      end
      if (pend) begin
        if (cnt == 0) begin
          imul_valid_in = 1'b1;
          imul_result = res;
          pend = 1'b0;
        end else cnt--;
      end
      if (hold_low > 0 && imul_valid_o) begin
        imul_ready = 1'b0;
        hold_low--;
      end else imul_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Compare process: request operands, operand stability, single-pulse results.
  initial begin
    logic prev_hold, prev_pv;
    logic [31:0] prev_a, prev_b;
    logic [65:0] e;
    prev_hold = 1'b0;
    prev_pv = 1'b0;
    prev_a = 32'd0;
    prev_b = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_prod_q.delete();
        exp_lane_q.delete();
        prev_hold = 1'b0;
        prev_pv = 1'b0;
      end else begin
        if (imul_valid_o && prev_hold) check("operands_stable", {op_a, op_b}, {prev_a, prev_b});
        if (imul_valid_o && imul_ready && clk_en) begin
          if (exp_lane_q.size() == 0) check("unexpected_request", 1'b1, 1'b0);
          else begin
            e = exp_lane_q.pop_front();
            check("request_lane", {imul_sgn, op_a, op_b}, e);
          end
        end
        if (vp_valid) begin
          check("vproduct_single_pulse", prev_pv, 1'b0);
          if (exp_prod_q.size() == 0) check("unexpected_vproduct", 1'b1, 1'b0);
          else check("vproduct_model", vproduct, exp_prod_q.pop_front());
        end
        prev_hold = imul_valid_o && !(imul_ready && clk_en);
        prev_pv = vp_valid;
        prev_a = op_a;
        prev_b = op_b;
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic [1:0] tv,
                        input logic [1:0] ts, output int lat);
    bit acc, got;
    @(posedge clk);
    #1;
    a = ta; b = tb2; vlen = tv; sgn = ts; dv = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(posedge clk);
      if (ready_o && clk_en) acc = 1'b1;
    end
    #1 dv = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (vp_valid) got = 1'b1;
    end
    check("op_completed", {acc, got}, 2'b11);
  endtask

  initial begin
    int lat, rc;
    bit got;
    logic [31:0] sa, sb;
    rst = 1'b1; clk_en = 1'b1; dv = 1'b0;
    a = 32'd0; b = 32'd0; vlen = 2'd0; sgn = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready_o, 1'b1);
    check("reset_valids", {imul_valid_o, vp_valid}, 2'b00);
    check("reset_vproduct", vproduct, 64'd0);
    check("reset_operands", {op_a, op_b}, 64'd0);
    rst = 1'b0;

    rc = req_count;
    run_op(32'h0403_0201, 32'h0202_0202, 2'b00, 2'b00, lat);
    check("lit_4x8_unsigned", vproduct, 64'h0008_0006_0004_0002);
    check("lit_4x8_requests", req_count - rc, 4);

    run_op(32'h0000_0080, 32'h0000_00FF, 2'b00, 2'b10, lat);
    check("lit_8bit_mixed", vproduct, 64'h0000_0000_0000_8080);

    run_op(32'hFFFF_0003, 32'h0002_0005, 2'b01, 2'b11, lat);
    check("lit_2x16_signed", vproduct, 64'hFFFF_FFFE_0000_000F);

    rc = req_count;
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 2'b00, lat);
    check("lit_1x32_unsigned", vproduct, 64'h0000_0001_FFFF_FFFE);
    check("lit_1x32_requests", req_count - rc, 1);

    fast = 1'b1;
    run_op(32'h1122_3344, 32'h5566_7788, 2'b00, 2'b01, lat);
    check("min_latency_4x8", lat, 9);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 2'b00, lat);
    check("min_latency_2x16", lat, 5);
    fast = 1'b0;

    hold_low = 3;
    run_op(32'h0A0B_0C0D, 32'h0102_0304, 2'b00, 2'b00, lat);
    check("lit_backpressure", vproduct, 64'h000A_0016_0024_0034);

    // Reset while waiting on a slow product; the late product must be ignored.
    lat_force = 5;
    rc = req_count;
    @(posedge clk);
    #1;
    a = 32'h0005_0006; b = 32'h0007_0008; vlen = 2'b01; sgn = 2'b00; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      if (req_count != rc) got = 1'b1;
    end
    check("reset_test_request_seen", got, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_ready", {ready_o, imul_valid_o, vp_valid}, 3'b100);
    @(posedge clk);
    #3 rst = 1'b0;
    lat_force = -1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_state", {ready_o, imul_valid_o, vp_valid}, 3'b100);
    check("post_reset_outputs", {vproduct, op_a}, {64'd0, 32'd0});

    run_op(32'h0007_0003, 32'h0002_0004, 2'b01, 2'b00, lat);
    check("lit_2x16_after_reset", vproduct, 64'h0000_000E_0000_000C);

    // Clock enable low while a request is pending.
    hold_low = 100;
    @(posedge clk);
    #1;
    a = 32'h0102_0304; b = 32'h0101_0101; vlen = 2'b00; sgn = 2'b00; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    @(posedge clk);
    #1;
    sa = op_a; sb = op_b;
    clk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("clk_en_hold_valid", {imul_valid_o, ready_o}, 2'b10);
    check("clk_en_hold_operands", {op_a, op_b}, {sa, sb});
    check("clk_en_lane0", {sa, sb}, {32'h0000_0004, 32'h0000_0001});
    clk_en = 1'b1;
    hold_low = 0;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (vp_valid) got = 1'b1;
    end
    check("clk_en_completed", got, 1'b1);
    check("lit_clk_en_result", vproduct, 64'h0001_0002_0003_0004);

    rc = req_count;
    run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b11, 2'b11, lat);
    check("reserved_vproduct", vproduct, 64'd0);
    check("reserved_requests", req_count - rc, 0);
    check("reserved_latency", lat, 1);

    for (int k = 0; k < 40; k++) begin
      run_op($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), lat);
    end

    repeat (3) @(posedge clk);
    check("queues_drained", {exp_prod_q.size() == 0, exp_lane_q.size() == 0}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
